// File: rtl/utils_pkg.sv
// Shared types for the interrupt front-end: the FSM state encoding and the
// interrupt bundle handed to the CSR block.
package utils_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OFFER = 2'd1,
      ST_BUSY  = 2'd2
   } irq_ctrl_st_t;

   typedef struct packed {
      logic ext_irq;
      logic sw_irq;
      logic timer_irq;
   } s_irq_t;

endpackage

// File: rtl/irq_sync.sv
// Vector multi-flop synchroniser for asynchronous level inputs; every bit
// passes through STAGES flops and resets to 0.
module irq_sync #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [STAGES-1:0][WIDTH-1:0] sync_q;
   logic [STAGES-1:0][WIDTH-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d_i};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt front-end: synchronises raw lines, latches edge sources, picks the
// lowest-numbered eligible external source and runs the claim/complete handshake.
module irq_ctrl
   import utils_pkg::*;
#(
   parameter int                     NUM_EXT_IRQ = 8,
   parameter int                     SYNC_STAGES = 2,
   parameter logic [NUM_EXT_IRQ-1:0] EDGE_MASK   = '0
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_EXT_IRQ-1:0]               ext_irq_i,
   input  logic                                 sw_irq_i,
   input  logic                                 timer_irq_i,
   input  logic [NUM_EXT_IRQ-1:0]               ext_en_i,
   input  logic                                 claim_i,
   input  logic                                 complete_i,
   input  logic [$clog2(NUM_EXT_IRQ+1)-1:0]     complete_id_i,
   output s_irq_t                               irq_o,
   output logic [$clog2(NUM_EXT_IRQ+1)-1:0]     ext_id_o
);

   localparam int EXT_ID_W = $clog2(NUM_EXT_IRQ + 1);
   localparam int SYNC_W   = NUM_EXT_IRQ + 2;

   logic [SYNC_W-1:0]      sync_out;
   logic [NUM_EXT_IRQ-1:0] ext_s;
   logic                   sw_s;
   logic                   timer_s;

   irq_sync #(
      .WIDTH  (SYNC_W),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i ({timer_irq_i, sw_irq_i, ext_irq_i}),
      .q_o (sync_out)
   );

   assign ext_s   = sync_out[NUM_EXT_IRQ-1:0];
   assign sw_s    = sync_out[NUM_EXT_IRQ];
   assign timer_s = sync_out[NUM_EXT_IRQ+1];

   // Lowest index wins; returns 1-based ID, 0 when nothing is set.
   function automatic logic [EXT_ID_W-1:0] prio_enc(input logic [NUM_EXT_IRQ-1:0] vec);
      logic [EXT_ID_W-1:0] id;
      id = '0;
      for (int i = NUM_EXT_IRQ - 1; i >= 0; i--) begin
         if (vec[i]) begin
            id = EXT_ID_W'(i + 1);
         end
      end
      return id;
   endfunction

   function automatic logic [NUM_EXT_IRQ-1:0] id_onehot(input logic [EXT_ID_W-1:0] id);
      logic [NUM_EXT_IRQ-1:0] oh;
      oh = '0;
      for (int i = 0; i < NUM_EXT_IRQ; i++) begin
         if (id == EXT_ID_W'(i + 1)) begin
            oh[i] = 1'b1;
         end
      end
      return oh;
   endfunction

   irq_ctrl_st_t           state_q, state_d;
   logic [EXT_ID_W-1:0]    id_q, id_d;
   logic                   ext_irq_q, ext_irq_d;
   logic                   sw_q, sw_d;
   logic                   timer_q, timer_d;
   logic [NUM_EXT_IRQ-1:0] ext_prev_q, ext_prev_d;
   logic [NUM_EXT_IRQ-1:0] edge_pend_q, edge_pend_d;
   logic [NUM_EXT_IRQ-1:0] in_service_q, in_service_d;

   logic [NUM_EXT_IRQ-1:0] pending;
   logic [NUM_EXT_IRQ-1:0] eligible;
   logic [NUM_EXT_IRQ-1:0] id_oh;
   logic [NUM_EXT_IRQ-1:0] edge_set;
   logic [NUM_EXT_IRQ-1:0] claim_clr;
   logic [EXT_ID_W-1:0]    win_id;
   logic                   claim_ok;

   for (genvar gi = 0; gi < NUM_EXT_IRQ; gi++) begin : g_pend
      assign pending[gi] = EDGE_MASK[gi] ? edge_pend_q[gi] : ext_s[gi];
   end

   assign eligible  = pending & ext_en_i & ~in_service_q;
   assign win_id    = prio_enc(eligible);
   assign id_oh     = id_onehot(id_q);
   assign claim_ok  = (state_q == ST_OFFER) && claim_i;
   assign edge_set  = ext_s & ~ext_prev_q & EDGE_MASK;
   assign claim_clr = claim_ok ? id_oh : '0;

   // A fresh edge in the claim cycle must survive, so set is applied after clear.
   always_comb begin
      ext_prev_d  = ext_s;
      sw_d        = sw_s;
      timer_d     = timer_s;
      edge_pend_d = ((edge_pend_q & ~claim_clr) | edge_set) & EDGE_MASK;
   end

   always_comb begin
      state_d      = state_q;
      id_d         = id_q;
      ext_irq_d    = ext_irq_q;
      in_service_d = in_service_q;
      case (state_q)
         ST_IDLE: begin
            id_d      = '0;
            ext_irq_d = 1'b0;
            if (win_id != '0) begin
               state_d   = ST_OFFER;
               id_d      = win_id;
               ext_irq_d = 1'b1;
            end
         end
         ST_OFFER: begin
            if (claim_i) begin
               state_d      = ST_BUSY;
               in_service_d = in_service_q | id_oh;
               ext_irq_d    = 1'b0;
            end else if ((eligible & id_oh) == '0) begin
               state_d   = ST_IDLE;
               id_d      = '0;
               ext_irq_d = 1'b0;
            end else begin
               id_d = win_id;
            end
         end
         ST_BUSY: begin
            // Claimed source is masked by in_service, so this flags only others.
            ext_irq_d = (eligible != '0);
            if (complete_i && (complete_id_i == id_q)) begin
               in_service_d = in_service_q & ~id_oh;
               if (win_id != '0) begin
                  state_d   = ST_OFFER;
                  id_d      = win_id;
                  ext_irq_d = 1'b1;
               end else begin
                  state_d   = ST_IDLE;
                  id_d      = '0;
                  ext_irq_d = 1'b0;
               end
            end
         end
         default: begin
            state_d   = ST_IDLE;
            id_d      = '0;
            ext_irq_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         id_q         <= '0;
         ext_irq_q    <= 1'b0;
         sw_q         <= 1'b0;
         timer_q      <= 1'b0;
         ext_prev_q   <= '0;
         edge_pend_q  <= '0;
         in_service_q <= '0;
      end else begin
         state_q      <= state_d;
         id_q         <= id_d;
         ext_irq_q    <= ext_irq_d;
         sw_q         <= sw_d;
         timer_q      <= timer_d;
         ext_prev_q   <= ext_prev_d;
         edge_pend_q  <= edge_pend_d;
         in_service_q <= in_service_d;
      end
   end

   always_comb begin
      irq_o.ext_irq   = ext_irq_q;
      irq_o.sw_irq    = sw_q;
      irq_o.timer_irq = timer_q;
   end

   assign ext_id_o = id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed handshake scenarios plus random
// traffic, compared every cycle against a transaction-level reference model.
module tb_irq_ctrl;
   import utils_pkg::*;

   localparam int            N  = 8;
   localparam int            S  = 2;
   localparam int            W  = 4;
   localparam logic [N-1:0]  EM = 8'h04;

   typedef struct packed {
      logic         tm;
      logic         sw;
      logic [N-1:0] ext;
   } raw_t;

   logic         clk;
   logic         rst;
   logic [N-1:0] ext_raw;
   logic         sw_raw;
   logic         tm_raw;
   logic [N-1:0] en;
   logic         claim;
   logic         complete;
   logic [W-1:0] complete_id;
   s_irq_t       irq_o;
   logic [W-1:0] ext_id_o;

   irq_ctrl #(
      .NUM_EXT_IRQ (N),
      .SYNC_STAGES (S),
      .EDGE_MASK   (EM)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ext_irq_i     (ext_raw),
      .sw_irq_i      (sw_raw),
      .timer_irq_i   (tm_raw),
      .ext_en_i      (en),
      .claim_i       (claim),
      .complete_i    (complete),
      .complete_id_i (complete_id),
      .irq_o         (irq_o),
      .ext_id_o      (ext_id_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // Reference model: which ID is offered, which is in service, latched edges.
   raw_t         m_pipe[$];
   logic [N-1:0] m_prev;
   logic [N-1:0] m_epend;
   int           m_offer;
   int           m_svc;
   bit           m_ext, m_sw, m_tm;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_irq();
      return 32'({m_ext, m_sw, m_tm});
   endfunction

   function automatic logic [31:0] exp_id();
      return (m_svc != 0) ? 32'(m_svc) : 32'(m_offer);
   endfunction

   function automatic bit exp_offering();
      return (m_svc == 0) && (m_offer != 0);
   endfunction

   task automatic model_reset();
      m_pipe.delete();
      for (int k = 0; k < S; k++) m_pipe.push_back('0);
      m_prev  = '0;
      m_epend = '0;
      m_offer = 0;
      m_svc   = 0;
      m_ext   = 1'b0;
      m_sw    = 1'b0;
      m_tm    = 1'b0;
   endtask

   task automatic model_step();
      raw_t         s;
      raw_t         now;
      logic [N-1:0] pend;
      logic [N-1:0] elig;
      int           win;
      bit           claim_ok;
      bit           done;
      s = m_pipe[0];
      for (int i = 0; i < N; i++) pend[i] = EM[i] ? m_epend[i] : s.ext[i];
      elig = pend & en;
      if (m_svc != 0) elig[m_svc-1] = 1'b0;
      win = 0;
      for (int i = N - 1; i >= 0; i--) if (elig[i]) win = i + 1;
      claim_ok = claim && exp_offering();
      done     = complete && (m_svc != 0) && (int'(complete_id) == m_svc);
      for (int i = 0; i < N; i++) begin
         if (EM[i]) begin
            if (s.ext[i] && !m_prev[i]) m_epend[i] = 1'b1;
            else if (claim_ok && m_offer == i + 1) m_epend[i] = 1'b0;
         end
      end
      if (m_svc != 0) begin
         if (done) begin
            m_svc   = 0;
            m_offer = win;
            m_ext   = (win != 0);
         end else begin
            m_ext = (elig != '0);
         end
      end else if (m_offer != 0) begin
         if (claim_ok) begin
            m_svc   = m_offer;
            m_offer = 0;
            m_ext   = 1'b0;
         end else if (!elig[m_offer-1]) begin
            m_offer = 0;
            m_ext   = 1'b0;
         end else begin
            m_offer = win;
         end
      end else begin
         m_offer = win;
         m_ext   = (win != 0);
      end
      m_sw   = s.sw;
      m_tm   = s.tm;
      m_prev = s.ext;
      now.tm  = tm_raw;
      now.sw  = sw_raw;
      now.ext = ext_raw;
      m_pipe.push_back(now);
      void'(m_pipe.pop_front());
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      if (rst) model_reset();
      else     model_step();
      #2;
      check_eq("irq_o", 32'(irq_o), exp_irq());
      check_eq("ext_id", 32'(ext_id_o), exp_id());
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      model_reset();
      #1;
      check_eq("rst_irq", 32'(irq_o), 32'd0);
      check_eq("rst_id", 32'(ext_id_o), 32'd0);
      ticks(n);
      rst = 1'b0;
   endtask

   task automatic pulse_claim();
      claim = 1'b1;
      tick();
      claim = 1'b0;
   endtask

   task automatic pulse_complete(input int id);
      complete    = 1'b1;
      complete_id = W'(id);
      tick();
      complete    = 1'b0;
      complete_id = '0;
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
      $fatal(1, "timeout");
   end

   int b;
   int pre_id;
   bit will_claim;
   bit will_done;

   initial begin
      rst         = 1'b1;
      ext_raw     = '0;
      sw_raw      = 1'b0;
      tm_raw      = 1'b0;
      en          = 8'hFF;
      claim       = 1'b0;
      complete    = 1'b0;
      complete_id = '0;
      model_reset();
      @(posedge clk);
      #2;
      do_reset(3);

      // 1: idle with everything low
      ticks(20);
      check_eq("t1_irq", 32'(irq_o), 32'd0);
      check_eq("t1_id", 32'(ext_id_o), 32'd0);
      $display("txn t1 idle cyc=%0d", cyc);

      // 2: timer and software level latency, both directions
      tm_raw = 1'b1;
      ticks(2);
      check_eq("t2_tm_early", 32'(irq_o.timer_irq), 32'd0);
      tick();
      check_eq("t2_tm_rise", 32'(irq_o.timer_irq), 32'd1);
      tm_raw = 1'b0;
      ticks(2);
      check_eq("t2_tm_hold", 32'(irq_o.timer_irq), 32'd1);
      tick();
      check_eq("t2_tm_fall", 32'(irq_o.timer_irq), 32'd0);
      sw_raw = 1'b1;
      ticks(2);
      check_eq("t2_sw_early", 32'(irq_o.sw_irq), 32'd0);
      tick();
      check_eq("t2_sw_rise", 32'(irq_o.sw_irq), 32'd1);
      sw_raw = 1'b0;
      ticks(3);
      check_eq("t2_sw_fall", 32'(irq_o.sw_irq), 32'd0);
      $display("txn t2 sw/timer cyc=%0d", cyc);

      // 3: single-cycle pulse on edge source 3
      ext_raw[2] = 1'b1;
      tick();
      ext_raw[2] = 1'b0;
      ticks(2);
      check_eq("t3_not_yet", 32'(irq_o.ext_irq), 32'd0);
      tick();
      check_eq("t3_irq", 32'(irq_o.ext_irq), 32'd1);
      check_eq("t3_id", 32'(ext_id_o), 32'd3);
      pulse_claim();
      check_eq("t3_claim_irq", 32'(irq_o.ext_irq), 32'd0);
      check_eq("t3_claim_id", 32'(ext_id_o), 32'd3);
      ticks(3);
      check_eq("t3_busy_id", 32'(ext_id_o), 32'd3);
      pulse_complete(3);
      check_eq("t3_done_id", 32'(ext_id_o), 32'd0);
      ticks(3);
      $display("txn t3 edge claim/complete id=3 cyc=%0d", cyc);

      // 4: level sources 1 and 5 together
      ext_raw[0] = 1'b1;
      ext_raw[4] = 1'b1;
      ticks(3);
      check_eq("t4_first", 32'(ext_id_o), 32'd1);
      pulse_claim();
      tick();
      check_eq("t4_busy_irq", 32'(irq_o.ext_irq), 32'd1);
      check_eq("t4_busy_id", 32'(ext_id_o), 32'd1);
      pulse_complete(2);
      check_eq("t4_bad_cmp", 32'(ext_id_o), 32'd1);
      ext_raw[0] = 1'b0;
      ticks(3);
      pulse_complete(1);
      check_eq("t4_next", 32'(ext_id_o), 32'd5);
      pulse_claim();
      ext_raw[4] = 1'b0;
      ticks(3);
      pulse_complete(5);
      check_eq("t4_done", 32'(ext_id_o), 32'd0);
      ticks(2);
      $display("txn t4 level ids 1,5 cyc=%0d", cyc);

      // 5: offered source disabled before claim
      ext_raw[5] = 1'b1;
      ticks(3);
      check_eq("t5_offer", 32'(ext_id_o), 32'd6);
      en[5] = 1'b0;
      tick();
      check_eq("t5_withdraw_irq", 32'(irq_o.ext_irq), 32'd0);
      check_eq("t5_withdraw_id", 32'(ext_id_o), 32'd0);
      pulse_claim();
      ticks(2);
      check_eq("t5_claim_ign", 32'(ext_id_o), 32'd0);
      ext_raw[5] = 1'b0;
      ticks(3);
      en = 8'hFF;
      ticks(2);
      $display("txn t5 withdraw id=6 cyc=%0d", cyc);

      // 6: edge arriving in the claim cycle survives; reset drops everything
      ext_raw[2] = 1'b1;
      tick();
      ext_raw[2] = 1'b0;
      ticks(3);
      check_eq("t6_offer", 32'(ext_id_o), 32'd3);
      ext_raw[2] = 1'b1;
      tick();
      ext_raw[2] = 1'b0;
      tick();
      pulse_claim();
      check_eq("t6_claim_id", 32'(ext_id_o), 32'd3);
      ticks(2);
      pulse_complete(3);
      tick();
      check_eq("t6_reoffer_irq", 32'(irq_o.ext_irq), 32'd1);
      check_eq("t6_reoffer_id", 32'(ext_id_o), 32'd3);
      pulse_claim();
      ext_raw[2] = 1'b1;
      tick();
      ext_raw[2] = 1'b0;
      ticks(3);
      do_reset(2);
      ticks(10);
      check_eq("t6_after_rst_id", 32'(ext_id_o), 32'd0);
      check_eq("t6_after_rst_irq", 32'(irq_o.ext_irq), 32'd0);
      $display("txn t6 set-wins and reset cyc=%0d", cyc);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) do_reset(2);
         if ($urandom_range(0, 9) == 0) begin
            b = $urandom_range(0, N - 1);
            ext_raw[b] = ~ext_raw[b];
         end
         if ($urandom_range(0, 19) == 0) sw_raw = ~sw_raw;
         if ($urandom_range(0, 19) == 0) tm_raw = ~tm_raw;
         if ($urandom_range(0, 39) == 0) begin
            b = $urandom_range(0, N - 1);
            en[b] = ~en[b];
         end
         if ($urandom_range(0, 99) == 0) en = 8'hFF;
         claim = (exp_offering() && $urandom_range(0, 2) == 0) || ($urandom_range(0, 49) == 0);
         complete = ($urandom_range(0, 4) == 0);
         if (m_svc != 0 && $urandom_range(0, 3) != 0) complete_id = W'(m_svc);
         else complete_id = W'($urandom_range(0, 15));
         pre_id     = int'(exp_id());
         will_claim = claim && exp_offering();
         will_done  = complete && (m_svc != 0) && (int'(complete_id) == m_svc);
         tick();
         if (will_claim) $display("txn claim id=%0d cyc=%0d", pre_id, cyc);
         if (will_done)  $display("txn complete id=%0d cyc=%0d", pre_id, cyc);
         claim       = 1'b0;
         complete    = 1'b0;
         complete_id = '0;
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
